// File: rtl/ip4_rtl_spa_wb.sv
// Writeback buffer behind the stream processor array: queues result bundles
// and serialises their enabled slots onto one register-file write port.
module ip4_rtl_spa_wb #(
  parameter int unsigned NRES   = 3,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       res_vld,
  output logic                       res_rdy,
  input  logic [NRES-1:0]            res_en,
  input  logic [NRES*ADDR_W-1:0]     res_addr,
  input  logic [NRES*WORD_W-1:0]     res_data,
  input  logic                       flush,
  input  logic                       rf_stall,
  output logic                       rf_we,
  output logic [ADDR_W-1:0]          rf_waddr,
  output logic [WORD_W-1:0]          rf_wdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       idle
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned SW = $clog2(NRES) + 1;

  logic [NRES-1:0]        en_q   [DEPTH];
  logic [NRES*ADDR_W-1:0] addr_q [DEPTH];
  logic [NRES*WORD_W-1:0] data_q [DEPTH];

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sp;

  logic empty;
  logic full;
  logic push;
  logic pop;

  logic [NRES-1:0]        head_en;
  logic [NRES*ADDR_W-1:0] head_addr;
  logic [NRES*WORD_W-1:0] head_data;

  logic [NRES-1:0] avail;
  logic            found;
  logic            more;
  logic [SW-1:0]   sel;
  logic [ADDR_W-1:0] sel_addr;
  logic [WORD_W-1:0] sel_data;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

  assign res_rdy = !full && !flush;
  assign push    = res_vld && res_rdy;

  assign count = cnt;
  assign idle  = empty;

  assign head_en   = en_q[rptr];
  assign head_addr = addr_q[rptr];
  assign head_data = data_q[rptr];

  // Slot select: lowest enabled slot at or above the slot pointer.
  always_comb begin
    avail    = '0;
    found    = 1'b0;
    more     = 1'b0;
    sel      = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < int'(NRES); i++) begin
      avail[i] = head_en[i] && (SW'(i) >= sp);
    end
    for (int i = int'(NRES) - 1; i >= 0; i--) begin
      if (avail[i]) begin
        found    = 1'b1;
        sel      = SW'(i);
        sel_addr = head_addr[i*ADDR_W +: ADDR_W];
        sel_data = head_data[i*WORD_W +: WORD_W];
      end
    end
    for (int i = 0; i < int'(NRES); i++) begin
      if (avail[i] && (SW'(i) > sel)) begin
        more = 1'b1;
      end
    end
  end

  assign rf_we = !empty && found && !rf_stall && !flush && !rst;

  // A head with nothing left to write retires without touching the port.
  assign pop = !empty && !flush && !rst &&
               (!found || (rf_we && !more));

  assign rf_waddr = (!empty && found) ? sel_addr : '0;
  assign rf_wdata = (!empty && found) ? sel_data : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      en_q[wptr]   <= res_en;
      addr_q[wptr] <= res_addr;
      data_q[wptr] <= res_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      sp   <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      sp   <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (pop) begin
        sp <= '0;
      end else if (rf_we) begin
        sp <= sel + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ip4_rtl_spa_wb.sv
// Directed bench for the SPA writeback buffer with a write-order
// scoreboard and a small register-file model.
module tb_ip4_rtl_spa_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_vld;
  logic        res_rdy;
  logic [2:0]  res_en;
  logic [17:0] res_addr;
  logic [95:0] res_data;
  logic        flush;
  logic        rf_stall;
  logic        rf_we;
  logic [5:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  count;
  logic        idle;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q [$];
  wr_t         e_m;
  logic [31:0] rf [64];

  always #5 clk = ~clk;

  ip4_rtl_spa_wb dut (
    .clk      (clk),
    .rst      (rst),
    .res_vld  (res_vld),
    .res_rdy  (res_rdy),
    .res_en   (res_en),
    .res_addr (res_addr),
    .res_data (res_data),
    .flush    (flush),
    .rf_stall (rf_stall),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .count    (count),
    .idle     (idle)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bundle(input logic [2:0] en, input logic [17:0] a,
                        input logic [95:0] d);
    res_vld  = 1'b1;
    res_en   = en;
    res_addr = a;
    res_data = d;
  endtask

  task automatic no_bundle();
    res_vld = 1'b0;
    res_en  = '0;
  endtask

  task automatic wait_idle(input string tag, input int n);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
      if (idle) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, ok, 1'b1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_idle"}, idle, 1);
    chk({tag, "_rdy"}, res_rdy, 1);
    chk({tag, "_we"}, rf_we, 0);
    chk({tag, "_waddr"}, rf_waddr, 0);
    chk({tag, "_wdata"}, rf_wdata, 0);
  endtask

  // Writes must appear in push order, ascending slot order.
  always begin
    @(negedge clk);
    #2;
    if (rf_we) begin
      if (exp_q.size() == 0) begin
        chk("sb_spurious_we", 1, 0);
      end else begin
        e_m = exp_q.pop_front();
        chk("sb_addr", rf_waddr, e_m.a);
        chk("sb_data", rf_wdata, e_m.d);
      end
      rf[rf_waddr] = rf_wdata;
    end
    if (rst || flush) begin
      exp_q.delete();
    end else if (res_vld && res_rdy) begin
      for (int i = 0; i < 3; i++) begin
        if (res_en[i]) begin
          exp_q.push_back({res_addr[i*6 +: 6], res_data[i*32 +: 32]});
        end
      end
    end
  end

  initial begin
    int   acc;
    int   nw;
    int   first;
    int   last;
    int   cyc;
    logic saw_drop;
    logic done;
    logic [7:0] pat;

    rst      = 1'b1;
    flush    = 1'b0;
    rf_stall = 1'b0;
    res_addr = '0;
    res_data = '0;
    no_bundle();
    repeat (2) @(negedge clk);

    // Reset state, then single bundle en=101
    rst = 1'b0;
    #1;
    chk_reset("rst");
    bundle(3'b101, {6'd5, 6'd9, 6'd2}, {32'hA, 32'hB, 32'hC});
    @(negedge clk);
    no_bundle();
    #1;
    chk("t1_we0", rf_we, 1);
    chk("t1_addr0", rf_waddr, 2);
    chk("t1_data0", rf_wdata, 32'hC);
    chk("t1_count", count, 1);
    @(negedge clk);
    #1;
    chk("t1_we1", rf_we, 1);
    chk("t1_addr1", rf_waddr, 5);
    chk("t1_data1", rf_wdata, 32'hA);
    @(negedge clk);
    #1;
    chk("t1_we_end", rf_we, 0);
    chk("t1_count_end", count, 0);
    chk("t1_idle_end", idle, 1);

    // Back-to-back full bundles
    acc = 0; nw = 0; first = -1; last = -1; cyc = 0;
    saw_drop = 1'b0; done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bundle(3'b111, {6'(c*3+2), 6'(c*3+1), 6'(c*3)},
             {32'(c*100+2), 32'(c*100+1), 32'(c*100)});
      #1;
      chk("t2_rdy", res_rdy, count != 3'd4);
      if (!res_rdy) saw_drop = 1'b1;
      if (res_rdy) acc++;
      if (rf_we) begin
        nw++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      cyc++;
    end
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (k == 0) no_bundle();
      #1;
      if (rf_we) begin
        nw++;
        last = cyc;
      end
      if (idle) done = 1'b1;
      cyc++;
    end
    chk("t2_timeout", done, 1);
    chk("t2_first_we", first, 1);
    chk("t2_nwrites", nw, 3*acc);
    chk("t2_no_gaps", last - first + 1, nw);
    chk("t2_rdy_dropped", saw_drop, 1);

    // Empty-enable bundle between two full ones
    @(negedge clk);
    bundle(3'b111, {6'd12, 6'd11, 6'd10}, {32'h12, 32'h11, 32'h10});
    @(negedge clk);
    bundle(3'b000, {6'd63, 6'd63, 6'd63}, {32'hF, 32'hF, 32'hF});
    #1;
    pat[7] = rf_we;
    @(negedge clk);
    bundle(3'b111, {6'd22, 6'd21, 6'd20}, {32'h22, 32'h21, 32'h20});
    #1;
    pat[6] = rf_we;
    @(negedge clk);
    no_bundle();
    #1;
    pat[5] = rf_we;
    @(negedge clk);
    #1;
    pat[4] = rf_we;
    chk("t3_count_zhead", count, 2);
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      #1;
      pat[i] = rf_we;
    end
    chk("t3_we_pattern", pat, 8'b1110_1110);

    // Stall after slot0
    @(negedge clk);
    bundle(3'b111, {6'd3, 6'd2, 6'd1}, {32'h33, 32'h22, 32'h11});
    @(negedge clk);
    no_bundle();
    #1;
    chk("t4_we_s0", rf_we, 1);
    chk("t4_addr_s0", rf_waddr, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rf_stall = 1'b1;
      #1;
      chk("t4_stall_we", rf_we, 0);
      chk("t4_hold_addr", rf_waddr, 2);
    end
    @(negedge clk);
    rf_stall = 1'b0;
    #1;
    chk("t4_we_s1", rf_we, 1);
    chk("t4_addr_s1", rf_waddr, 2);
    chk("t4_data_s1", rf_wdata, 32'h22);
    @(negedge clk);
    #1;
    chk("t4_addr_s2", rf_waddr, 3);
    chk("t4_data_s2", rf_wdata, 32'h33);
    @(negedge clk);
    #1;
    chk("t4_we_end", rf_we, 0);
    chk("t4_idle_end", idle, 1);

    // Flush with count=3 and an in-flight bundle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rf_stall = 1'b1;
      bundle(3'b111, {6'(30+i), 6'(31+i), 6'(32+i)}, {3{32'(i)}});
    end
    @(negedge clk);
    rf_stall = 1'b0;
    flush    = 1'b1;
    bundle(3'b111, {6'd40, 6'd41, 6'd42}, {3{32'hDEAD}});
    #1;
    chk("t5_count3", count, 3);
    chk("t5_rdy_flush", res_rdy, 0);
    chk("t5_we_flush", rf_we, 0);
    @(negedge clk);
    flush = 1'b0;
    no_bundle();
    #1;
    chk("t5_count0", count, 0);
    chk("t5_idle", idle, 1);
    chk("t5_we0", rf_we, 0);
    @(negedge clk);
    bundle(3'b010, {6'd0, 6'd4, 6'd0}, {32'h0, 32'h55, 32'h0});
    @(negedge clk);
    no_bundle();
    #1;
    chk("t5_new_we", rf_we, 1);
    chk("t5_new_addr", rf_waddr, 4);
    chk("t5_new_data", rf_wdata, 32'h55);
    @(negedge clk);
    #1;
    chk("t5_new_idle", idle, 1);

    // Duplicate address: last slot wins
    @(negedge clk);
    bundle(3'b111, {6'd7, 6'd7, 6'd7}, {32'd3, 32'd2, 32'd1});
    @(negedge clk);
    no_bundle();
    wait_idle("t6_timeout", 10);
    chk("t6_rf7", rf[7], 3);

    // Reset mid-drain with count=2
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rf_stall = 1'b1;
      bundle(3'b111, {6'(50+i), 6'(53+i), 6'(56+i)}, {3{32'(16+i)}});
    end
    @(negedge clk);
    no_bundle();
    rf_stall = 1'b0;
    #1;
    chk("t7_count2", count, 2);
    chk("t7_we", rf_we, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t7_we_rst", rf_we, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset("t7");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("t7_no_stale", rf_we, 0);
    end

    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
